led_pattern_driver: RTL and testbench

Fabric-side consumer of the 8-bit LED PIO output word. Synchronises the word into `clk`, rejects transient multi-bit values with a stability filter, and drives the eight board LEDs with global PWM dimming, optional blink, and a heartbeat on LED 7. Sits between the LED PIO `out_port` and the top-level LED pins.

---
 rtl/led_drv_pkg.sv | 12 +
 rtl/led_sync_filter.sv | 52 +++++
 rtl/led_pattern_driver.sv | 67 ++++++
 tb/tb_led_pattern_driver.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/led_drv_pkg.sv
// led_drv_pkg: shared widths, reset pattern and bit positions for the LED pattern driver.
package led_drv_pkg;
    localparam int LED_W = 8;
    typedef logic [LED_W-1:0] led_word_t;
    localparam led_word_t LED_RESET_PATTERN = 8'h7F;
    localparam int BLINK_BIT = 7;
    localparam int HEARTBEAT_LED = 7;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/led_sync_filter.sv
// led_sync_filter: two-flop synchroniser plus stability filter for the PIO LED word.
module led_sync_filter
    import led_drv_pkg::*;
#(
    parameter int        STABLE_CYCLES = 4,
    parameter led_word_t RESET_VAL     = LED_RESET_PATTERN
) (
    input  logic      clk,
    input  logic      reset_n,
    input  led_word_t pattern_i,
    output led_word_t pattern_o,
    output logic      update_o,
    output logic      blink_rise_o
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    led_word_t sync1_q, sync2_q, cand_q, cand_d, pat_q, pat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic upd_q, changed, accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            cand_q  <= RESET_VAL;
            cnt_q   <= '0;
            pat_q   <= RESET_VAL;
            upd_q   <= 1'b0;
        end else begin
            sync1_q <= pattern_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            upd_q   <= accept;
        end
    end

    // cand always ends up equal to sync2; only the count cares whether it moved
    always_comb begin
        changed = sync2_q != cand_q;
        cand_d  = sync2_q;
        cnt_d   = changed ? '0 : (cnt_q != CNT_LAST) ? cnt_q + CW'(1) : cnt_q;
        accept  = !changed && cnt_q == CNT_LAST && cand_q != pat_q;
        pat_d   = accept ? cand_q : pat_q;
    end

    assign pattern_o    = pat_q;
    assign update_o     = upd_q;
    assign blink_rise_o = accept && cand_q[BLINK_BIT] && !pat_q[BLINK_BIT];
endmodule

// File: rtl/led_pattern_driver.sv
// led_pattern_driver: filtered PIO LED word driven to pins with PWM dimming, blink and heartbeat.
module led_pattern_driver
    import led_drv_pkg::*;
#(
    parameter int PWM_BITS      = 4,
    parameter int DUTY          = 8,
    parameter int BLINK_DIV     = 25_000_000,
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LED_W-1:0] pattern_in,
    output logic [LED_W-1:0] led,
    output logic [LED_W-1:0] pattern_q,
    output logic             update_pulse
);
    localparam int BW = cnt_width(BLINK_DIV);
    localparam logic [PWM_BITS:0] DUTY_W = (PWM_BITS + 1)'(DUTY);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam led_word_t LED_OFF = {LED_W{ACTIVE_LOW}};

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic blink_phase_q, blink_phase_d, blink_rise, wrap, pwm_on, gate;
    led_word_t led_q, on_d;

    led_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .RESET_VAL    (LED_RESET_PATTERN)
    ) u_filter (
        .clk         (clk),
        .reset_n     (reset_n),
        .pattern_i   (pattern_in),
        .pattern_o   (pattern_q),
        .update_o    (update_pulse),
        .blink_rise_o(blink_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            led_q         <= LED_OFF;
        end else begin
            pwm_cnt_q     <= pwm_cnt_q + PWM_BITS'(1);
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= on_d ^ LED_OFF;
        end
    end

    // entering blink mode restarts the blink in its on phase, overriding a wrap
    always_comb begin
        pwm_on        = {1'b0, pwm_cnt_q} < DUTY_W;
        wrap          = blink_cnt_q == BLINK_LAST;
        blink_cnt_d   = (blink_rise || wrap) ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = blink_rise ? 1'b1 : wrap ? !blink_phase_q : blink_phase_q;
        gate          = pattern_q[BLINK_BIT] ? blink_phase_q : 1'b1;
        on_d          = '0;
        for (int i = 0; i < LED_W; i++)
            on_d[i] = (i == HEARTBEAT_LED) ? blink_phase_q && pwm_on : pattern_q[i] && pwm_on && gate;
    end

    assign led = led_q;
endmodule

// File: tb/tb_led_pattern_driver.sv
// tb_led_pattern_driver: table-driven and directed checks of the LED pattern driver.
module tb_led_pattern_driver;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pattern_in = 8'h3C;
    logic [7:0] led_m, pq_m, led_2, pq_2, led_0, pq_0, led_a, pq_a;
    logic       up_m, up_2, up_0, up_a;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic [7:0] pin;
        logic [7:0] pq;
        logic       up;
        logic [6:0] led;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    led_pattern_driver #(.PWM_BITS(2), .DUTY(4), .BLINK_DIV(10), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_main (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .led(led_m), .pattern_q(pq_m), .update_pulse(up_m));
    led_pattern_driver #(.PWM_BITS(2), .DUTY(2), .BLINK_DIV(10), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_d2 (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .led(led_2), .pattern_q(pq_2), .update_pulse(up_2));
    led_pattern_driver #(.PWM_BITS(2), .DUTY(0), .BLINK_DIV(10), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_d0 (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .led(led_0), .pattern_q(pq_0), .update_pulse(up_0));
    led_pattern_driver #(.PWM_BITS(2), .DUTY(4), .BLINK_DIV(10), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .led(led_a), .pattern_q(pq_a), .update_pulse(up_a));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold pin for n edges; a changed word is accepted at the 7th edge (E6), pins follow at E7.
    function automatic void seg(input logic [7:0] pin, input int n, input logic [7:0] old_w, input logic [7:0] new_w);
        for (int k = 0; k < n; k++) begin
            vec_t v;
            v.pin = pin;
            v.pq  = (k >= 6) ? new_w : old_w;
            v.up  = (k == 6) && (new_w != old_w);
            v.led = (k >= 7) ? new_w[6:0] : old_w[6:0];
            tbl.push_back(v);
        end
    endfunction

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            pattern_in = tbl[i].pin;
            step();
            check($sformatf("%s_pq[%0d]", tag, i), pq_m, tbl[i].pq);
            check($sformatf("%s_up[%0d]", tag, i), 8'(up_m), 8'(tbl[i].up));
            check($sformatf("%s_led[%0d]", tag, i), {1'b0, led_m[6:0]}, {1'b0, tbl[i].led});
        end
        tbl.delete();
    endtask

    task automatic accept(input logic [7:0] w, output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        pattern_in = w;
        while (!ok && n < 20) begin
            step();
            n++;
            ok = up_m;
        end
        check($sformatf("accept_pulse_%h", w), 8'(ok), 8'd1);
        check($sformatf("accept_pq_%h", w), pq_m, w);
    endtask

    initial begin
        int n, m, cnt2;
        repeat (3) step();
        check("rst_led", led_m, 8'h00);
        check("rst_led_al", led_a, 8'hFF);
        check("rst_pq", pq_m, 8'h7F);
        check("rst_up", 8'(up_m), 8'd0);
        reset_n = 1'b1;
        seg(8'h3C, 8, 8'h7F, 8'h3C);
        seg(8'h7F, 8, 8'h3C, 8'h7F);
        seg(8'h05, 8, 8'h7F, 8'h05);
        seg(8'h3C, 3, 8'h05, 8'h05);
        seg(8'h05, 10, 8'h05, 8'h05);
        run_tbl("seq");

        accept(8'h01, n);
        check("pq_d2", pq_2, 8'h01);
        step();
        for (int w = 0; w < 3; w++) begin
            cnt2 = 0;
            for (int c = 0; c < 4; c++) begin
                step();
                cnt2 += int'(led_2[0]);
                check("pwm_d0", 8'(led_0[0]), 8'd0);
                check("pwm_d4", 8'(led_m[0]), 8'd1);
            end
            check("pwm_d2_window", 8'(cnt2), 8'd2);
        end

        accept(8'h81, n);
        m = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            m++;
            check($sformatf("blink0_m%0d", m), 8'(led_m[0]), 8'(((m - 1) / 10) % 2 == 0));
            check($sformatf("blink7_m%0d", m), 8'(led_m[7]), 8'(((m - 1) / 10) % 2 == 0));
        end
        accept(8'h01, n);
        m += n;
        for (int c = 0; c < 30; c++) begin
            step();
            m++;
            check($sformatf("steady0_m%0d", m), 8'(led_m[0]), 8'd1);
            check($sformatf("heart7_m%0d", m), 8'(led_m[7]), 8'(((m - 1) / 10) % 2 == 0));
        end

        pattern_in = 8'h05;
        repeat (4) step();
        reset_n = 1'b0;
        #2;
        check("midrst_led", led_m, 8'h00);
        check("midrst_led_al", led_a, 8'hFF);
        check("midrst_pq", pq_m, 8'h7F);
        check("midrst_pq_al", pq_a, 8'h7F);
        check("midrst_up", 8'(up_m), 8'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            check("inrst_up", 8'(up_m), 8'd0);
            check("inrst_led_al", led_a, 8'hFF);
        end
        reset_n = 1'b1;
        seg(8'h05, 8, 8'h7F, 8'h05);
        run_tbl("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
